router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//   Output buffer for one destination port of the 1x3 router; three instances
//   sit directly downstream of router_syn.
//   Accepts bytes when router_syn raises the matching write_enb bit and stores
//   them with a header-tag bit that marks the first byte of each packet.
//   Drains them to the destination when read_enb is asserted.
//   Reports full/empty back to router_syn, and clears itself on router_syn's
//   soft_reset.
// PARAMETERS
//   WIDTH  8   payload byte width
//   DEPTH  16  entries; power of two
//   AW     4   pointer width, log2(DEPTH)
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   soft_reset  in   1      synchronous flush, from router_syn soft_reset_N
//   write_enb   in   1      write strobe, from router_syn write_enb[N]
//   lfd_state   in   1      1 = data_in is the header byte of a new packet
//   data_in     in   WIDTH  byte to store
//   read_enb    in   1      read strobe from the destination
//   data_out    out  WIDTH  registered read data
//   full        out  1      count==DEPTH; to router_syn full_N
//   empty       out  1      count==0; to router_syn empty_N
//   pkt_busy    out  1      the packet being read still has bytes left (pkt_cnt!=0)
// BEHAVIOUR
//   - Storage: DEPTH x (WIDTH+1). Bit WIDTH holds lfd_state, captured at write time.
//   - Pointers: wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH.
//     count is AW+1 bits wide.
//   - full and empty are combinational from count.
//   - Async reset (rst=1):
//     - ptrs, count, data_out and pkt_cnt go to 0.
//     - empty=1, full=0, pkt_busy=0.
//     - Memory contents are don't-care.
//   - Priority at each clk edge: rst > soft_reset > read/write.
//   - soft_reset=1: same clears as rst, applied at the edge.
//     Any write_enb/read_enb in that cycle is ignored.
//   - Write accepted iff write_enb && !full: mem[wr_ptr]={lfd_state,data_in},
//     then wr_ptr++. A write while full is dropped; nothing else changes.
//   - Read accepted iff read_enb && !empty: data_out<=mem[rd_ptr][WIDTH-1:0],
//     then rd_ptr++.
//     - Latency: data_out is valid one edge after read_enb is sampled.
//     - read_enb while empty: data_out holds its value and pkt_cnt is unchanged.
//   - Simultaneous accepted read+write: count unchanged.
//     - When full, the read is accepted and the write is dropped, because full
//       is evaluated before the read.
//     - When empty, the write is accepted and the read is ignored; there is no
//       fall-through.
//   - Packet counter pkt_cnt (6 bits):
//     - On an accepted read of a tagged word: pkt_cnt <= data[7:2] + 1
//       (payload length plus parity byte).
//     - On an accepted read of an untagged word: pkt_cnt <= pkt_cnt - 1,
//       saturating at 0 (a malformed stream never underflows).
//     - A tagged word arriving while pkt_cnt!=0 reloads the counter
//       (new packet wins).
//   - Header length 0 loads 1, so the parity byte is still counted.
//   - Reset or soft_reset mid-packet drops all buffered data and clears pkt_cnt
//     within the same edge.
// TESTING
//   1. rst pulse while data is stored
//      -> empty=1, full=0, data_out=0x00, pkt_busy=0 immediately (async),
//         before the next edge.
//   2. Write header 0x14 (lfd=1), then 0xA1..0xA5 and parity 0x5C; then read 7
//      -> data_out sequence 0x14,0xA1..0xA5,0x5C.
//      -> pkt_busy=1 after the first read (pkt_cnt=6), 0 after the 7th read.
//      -> empty=1 at the end.
//   3. Write 16 bytes -> full=1; 17th write of 0xFF is dropped.
//      Reading 16 bytes returns the original 16; 0xFF never appears.
//   4. Full FIFO, read_enb=1 and write_enb=1 together with 0x77
//      -> full drops to 0 and count=15. Keep reading: 0x77 never appears.
//   5. Empty FIFO, write+read together with 0x33 -> empty=0, data_out unchanged.
//      Next read returns 0x33.
//   6. Mid-packet (3 of 7 read), pulse soft_reset with write_enb=1
//      -> empty=1, pkt_busy=0, data_out=0x00; the concurrent write is not stored.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo
// Output buffer for one destination port of the 1x3 router. Bytes from
// router_syn are stored together with a header-tag bit marking the first byte
// of each packet. The destination drains them with read_enb. A packet counter
// tracks how many bytes of the packet currently being read are still to come.
// full/empty are reported back to router_syn, and soft_reset flushes the buffer.

module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
);

    // Stored word: tag bit on top, payload byte below.
    localparam int TW = WIDTH + 1;
    // Width of the packet counter, which is also the width of the header
    // length field taken from the top of the header byte.
    localparam int PW = 6;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [TW-1:0]    mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [AW:0]      count_q,    count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [PW-1:0]    pkt_cnt_q,  pkt_cnt_d;

    logic             full_s;
    logic             empty_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [TW-1:0]    rd_word_s;

    // Status flags and transfer qualifiers. full is evaluated against the
    // count before any read in this cycle, so a write to a full buffer is
    // dropped even when a read happens at the same edge; likewise a read of
    // an empty buffer is ignored even alongside a write (no fall-through).
    // soft_reset suppresses both transfers in its cycle.
    always_comb begin
        full_s    = (count_q == FULL_CNT);
        empty_s   = (count_q == {(AW + 1){1'b0}});
        wr_acc_s  = write_enb && !full_s && !soft_reset;
        rd_acc_s  = read_enb  && !empty_s && !soft_reset;
        rd_word_s = mem_q[rd_ptr_q];
    end

    // Next-state computation for pointers, occupancy, read data and packet count.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (soft_reset) begin
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            count_d    = {(AW + 1){1'b0}};
            data_out_d = {WIDTH{1'b0}};
            pkt_cnt_d  = {PW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (rd_acc_s) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                data_out_d = rd_word_s[WIDTH-1:0];
                if (rd_word_s[WIDTH]) begin
                    // Header: payload length plus the trailing parity byte.
                    // A new header always reloads, even mid-packet.
                    pkt_cnt_d = rd_word_s[WIDTH-1 -: PW] + PW'(1);
                end else if (pkt_cnt_q != {PW{1'b0}}) begin
                    pkt_cnt_d = pkt_cnt_q - PW'(1);
                end else begin
                    // Malformed stream: stay at zero rather than underflow.
                    pkt_cnt_d = {PW{1'b0}};
                end
            end else begin
                rd_ptr_d   = rd_ptr_q;
                data_out_d = data_out_q;
                pkt_cnt_d  = pkt_cnt_q;
            end

            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                2'b11:   count_d = count_q;
                2'b00:   count_d = count_q;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW + 1){1'b0}};
            data_out_q <= {WIDTH{1'b0}};
            pkt_cnt_q  <= {PW{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Storage array; contents after reset are irrelevant, so it is not cleared.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign pkt_busy = (pkt_cnt_q != {PW{1'b0}});

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo
// Directed stimulus with a scoreboard: every read the stimulus expects to be
// accepted pushes its expected byte into exp_q; a forked monitor pops and
// compares data_out one edge later. Flag checks are done inline.

module tb_router_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    logic       rd_expect;
    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Called at a negedge; returns at the next
    // negedge with all strobes released, so state after the edge can be checked.
    task automatic cyc(input logic sr, input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic exprd, input logic [7:0] eb);
        soft_reset = sr;
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        rd_expect  = exprd;
        if (exprd) exp_q.push_back(eb);
        @(negedge clk);
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        rd_expect  = 1'b0;
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        cyc(1'b0, 1'b1, lfd, din, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [7:0] eb);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, eb);
    endtask

    initial begin
        logic [7:0] pkt [7];
        pkt[0] = 8'h14; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3;
        pkt[4] = 8'hA4; pkt[5] = 8'hA5; pkt[6] = 8'h5C;

        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        rd_expect  = 1'b0;

        fork
            begin : monitor
                logic       pend;
                logic [7:0] eb;
                forever begin
                    @(posedge clk);
                    pend = rd_expect;
                    @(negedge clk);
                    if (pend) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL rd_data: got 0x%0h expected nothing queued", data_out);
                        end else begin
                            eb = exp_q.pop_front();
                            check("rd_data", {24'h0, data_out}, {24'h0, eb});
                        end
                    end
                end
            end
        join_none

        // Reset state
        #1;
        check("rst_empty", {31'h0, empty}, 32'd1);
        check("rst_full", {31'h0, full}, 32'd0);
        check("rst_dout", {24'h0, data_out}, 32'h00);
        check("rst_busy", {31'h0, pkt_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Packet 0x14 (length 5) + 5 payload + parity, then drain
        for (int i = 0; i < 7; i++) wr(i == 0, pkt[i]);
        check("pkt_not_empty", {31'h0, empty}, 32'd0);
        rd(pkt[0]);
        check("pkt_busy_first", {31'h0, pkt_busy}, 32'd1);
        for (int i = 1; i < 6; i++) rd(pkt[i]);
        check("pkt_busy_sixth", {31'h0, pkt_busy}, 32'd1);
        rd(pkt[6]);
        check("pkt_busy_last", {31'h0, pkt_busy}, 32'd0);
        check("pkt_empty_end", {31'h0, empty}, 32'd1);

        // Header with length 0 still counts the parity byte
        wr(1'b1, 8'h01);
        wr(1'b0, 8'hEE);
        rd(8'h01);
        check("len0_busy", {31'h0, pkt_busy}, 32'd1);
        rd(8'hEE);
        check("len0_done", {31'h0, pkt_busy}, 32'd0);

        // Fill to 16, drop 17th write, drain original 16
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h10 + 8'(i));
        check("fill_full", {31'h0, full}, 32'd1);
        wr(1'b0, 8'hFF);
        check("drop_full", {31'h0, full}, 32'd1);
        for (int i = 0; i < 16; i++) rd(8'h10 + 8'(i));
        check("drain_empty", {31'h0, empty}, 32'd1);
        check("sat_busy", {31'h0, pkt_busy}, 32'd0);

        // Full: simultaneous read+write, write dropped
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h20 + 8'(i));
        cyc(1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 8'h20);
        check("rw_full_full", {31'h0, full}, 32'd0);
        check("rw_full_empty", {31'h0, empty}, 32'd0);
        for (int i = 1; i < 16; i++) rd(8'h20 + 8'(i));
        check("rw_full_drained", {31'h0, empty}, 32'd1);
        // Read while empty: data_out holds
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check("rd_empty_hold", {24'h0, data_out}, 32'h2F);

        // Empty: simultaneous write+read, no fall-through
        cyc(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'h00);
        check("rw_empty_empty", {31'h0, empty}, 32'd0);
        check("rw_empty_dout", {24'h0, data_out}, 32'h2F);
        rd(8'h33);
        check("rw_empty_after", {31'h0, empty}, 32'd1);

        // Soft reset mid-packet with concurrent write
        for (int i = 0; i < 7; i++) wr(i == 0, pkt[i]);
        for (int i = 0; i < 3; i++) rd(pkt[i]);
        check("mid_busy", {31'h0, pkt_busy}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00);
        check("srst_empty", {31'h0, empty}, 32'd1);
        check("srst_busy", {31'h0, pkt_busy}, 32'd0);
        check("srst_dout", {24'h0, data_out}, 32'h00);
        check("srst_full", {31'h0, full}, 32'd0);
        wr(1'b0, 8'h42);
        rd(8'h42);
        check("srst_after", {31'h0, empty}, 32'd1);

        // Asynchronous reset while data is stored
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h55);
        wr(1'b0, 8'h66);
        rd(8'h08);
        check("pre_arst_busy", {31'h0, pkt_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_empty", {31'h0, empty}, 32'd1);
        check("arst_full", {31'h0, full}, 32'd0);
        check("arst_dout", {24'h0, data_out}, 32'h00);
        check("arst_busy", {31'h0, pkt_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check("arst_still_empty", {31'h0, empty}, 32'd1);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
